// File: rtl/gpi_ctrl_pkg.sv
// Shared types and constants for the general-purpose input pad controller.
// Pad configuration layout matches the register write word {ste[1:0], pd, pu, ie}.
package gpi_ctrl_pkg;

  localparam int CFG_W = 5;

  typedef struct packed {
    logic [1:0] ste;
    logic       pd;
    logic       pu;
    logic       ie;
  } pad_cfg_t;

  typedef enum logic [1:0] {
    OFF,
    SETTLE,
    ACTIVE
  } chan_state_e;

endpackage

// File: rtl/gpi_pad_chan.sv
// One input pad channel: config register, OFF/SETTLE/ACTIVE sequencing,
// receiver synchronizer and debounce filter with edge pulses.
module gpi_pad_chan
  import gpi_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DEB_W         = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en,
  input  pad_cfg_t         wr_cfg,
  input  logic [DEB_W-1:0] deb_thresh,
  input  logic             di,
  output pad_cfg_t         cfg,
  output logic             settling,
  output logic             level,
  output logic             rise,
  output logic             fall
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

  chan_state_e            state_q, state_d;
  pad_cfg_t               cfg_q, cfg_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SET_W-1:0]       set_cnt_q, set_cnt_d;
  logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cfg_d     = wr_en ? wr_cfg : cfg_q;
    set_cnt_d = set_cnt_q;
    deb_cnt_d = '0;
    level_d   = level_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;

    unique case (state_q)
      OFF: begin
        level_d = 1'b0;
        if (wr_en && wr_cfg.ie) begin
          state_d   = SETTLE;
          set_cnt_d = '0;
        end
      end
      SETTLE: begin
        if (wr_en && !wr_cfg.ie) begin
          state_d = OFF;
          level_d = 1'b0;
        end else if (wr_en) begin
          set_cnt_d = '0;
        end else if (set_cnt_q == SET_LAST) begin
          // Trust the receiver from here on; adopt its level silently.
          state_d = ACTIVE;
          level_d = s;
        end else begin
          set_cnt_d = set_cnt_q + 1'b1;
        end
      end
      ACTIVE: begin
        if (wr_en && !wr_cfg.ie) begin
          state_d = OFF;
          level_d = 1'b0;
        end else if (wr_en && ((wr_cfg.pu != cfg_q.pu) || (wr_cfg.pd != cfg_q.pd))) begin
          state_d   = SETTLE;
          set_cnt_d = '0;
        end else if (s != level_q) begin
          // >= so a threshold lowered below the running count fires right away.
          if (deb_cnt_q >= deb_thresh) begin
            level_d = s;
            rise_d  = s;
            fall_d  = ~s;
          end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = OFF;
        level_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= OFF;
      cfg_q     <= '0;
      sync_q    <= '0;
      set_cnt_q <= '0;
      deb_cnt_q <= '0;
      level_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], di};
      set_cnt_q <= set_cnt_d;
      deb_cnt_q <= deb_cnt_d;
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  assign cfg      = cfg_q;
  assign settling = (state_q == SETTLE);
  assign level    = level_q;
  assign rise     = rise_q;
  assign fall     = fall_q;

endmodule

// File: rtl/gpi_pad_ctrl.sv
// Bank of general-purpose input pad controllers: config write decode, ready mux,
// out-of-range error pulse and per-pad channel instances.
module gpi_pad_ctrl
  import gpi_ctrl_pkg::*;
#(
  parameter int NUM_PADS      = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int DEB_W         = 8,
  parameter int SETTLE_CYCLES = 4,
  localparam int IDX_W        = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [IDX_W-1:0]      cfg_idx_i,
  input  logic [CFG_W-1:0]      cfg_data_i,
  output logic                  cfg_err_o,
  input  logic [DEB_W-1:0]      deb_thresh_i,
  output logic [NUM_PADS-1:0]   pad_ie_o,
  output logic [NUM_PADS-1:0]   pad_pu_o,
  output logic [NUM_PADS-1:0]   pad_pd_o,
  output logic [2*NUM_PADS-1:0] pad_ste_o,
  input  logic [NUM_PADS-1:0]   pad_di_i,
  output logic [NUM_PADS-1:0]   level_o,
  output logic [NUM_PADS-1:0]   rise_o,
  output logic [NUM_PADS-1:0]   fall_o
);

  logic                idx_ok;
  logic                accept;
  logic [NUM_PADS-1:0] settling;
  pad_cfg_t            chan_cfg [NUM_PADS];

  // Out-of-range codes exist only when NUM_PADS is not a power of two.
  assign idx_ok = (32'(cfg_idx_i) < 32'(NUM_PADS));
  assign accept = cfg_valid_i && cfg_ready_o;

  always_comb begin
    cfg_ready_o = 1'b1;
    for (int k = 0; k < NUM_PADS; k++) begin
      if (idx_ok && (cfg_idx_i == IDX_W'(k))) cfg_ready_o = ~settling[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cfg_err_o <= 1'b0;
    else         cfg_err_o <= accept && !idx_ok;
  end

  for (genvar k = 0; k < NUM_PADS; k++) begin : g_chan
    logic wr_en;
    assign wr_en = accept && idx_ok && (cfg_idx_i == IDX_W'(k));

    gpi_pad_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEB_W        (DEB_W),
      .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_chan (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .wr_en     (wr_en),
      .wr_cfg    (pad_cfg_t'(cfg_data_i)),
      .deb_thresh(deb_thresh_i),
      .di        (pad_di_i[k]),
      .cfg       (chan_cfg[k]),
      .settling  (settling[k]),
      .level     (level_o[k]),
      .rise      (rise_o[k]),
      .fall      (fall_o[k])
    );

    assign pad_ie_o[k]        = chan_cfg[k].ie;
    assign pad_pu_o[k]        = chan_cfg[k].pu;
    assign pad_pd_o[k]        = chan_cfg[k].pd;
    assign pad_ste_o[2*k+:2]  = chan_cfg[k].ste;
  end

endmodule

// File: tb/tb_gpi_pad_ctrl.sv
// Self-checking bench for gpi_pad_ctrl: directed vector table, corner-case
// sequences and randomized traffic against a behavioural pad model.
module tb_gpi_pad_ctrl;
  import gpi_ctrl_pkg::*;

  // Six pads leave index codes 6 and 7 free to exercise the out-of-range path.
  localparam int N  = 6;
  localparam int SS = 2;
  localparam int DW = 8;
  localparam int SC = 4;
  localparam int IW = 3;

  logic            clk_i  = 1'b0;
  logic            rst_ni = 1'b0;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [IW-1:0]   cfg_idx = '0;
  logic [4:0]      cfg_data = '0;
  logic            cfg_err;
  logic [DW-1:0]   deb_thresh = 8'd3;
  logic [N-1:0]    pad_ie, pad_pu, pad_pd, level, rise, fall;
  logic [2*N-1:0]  pad_ste;
  logic [N-1:0]    pad_di = '0;

  always #5 clk_i = ~clk_i;

  gpi_pad_ctrl #(
    .NUM_PADS(N), .SYNC_STAGES(SS), .DEB_W(DW), .SETTLE_CYCLES(SC)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_idx_i(cfg_idx),
    .cfg_data_i(cfg_data), .cfg_err_o(cfg_err), .deb_thresh_i(deb_thresh),
    .pad_ie_o(pad_ie), .pad_pu_o(pad_pu), .pad_pd_o(pad_pd), .pad_ste_o(pad_ste),
    .pad_di_i(pad_di), .level_o(level), .rise_o(rise), .fall_o(fall)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = off, 1 = settling, 2 = active.
  int          m_mode [N];
  int          m_left [N];
  int          m_run  [N];
  logic        m_level[N];
  logic        m_rise [N];
  logic        m_fall [N];
  logic [4:0]  m_cfg  [N];
  logic        m_err;
  logic [N-1:0] m_hist[$];

  function automatic logic m_ready(input int idx);
    return (idx >= N) || (m_mode[idx] != 1);
  endfunction

  task automatic model_reset();
    for (int p = 0; p < N; p++) begin
      m_mode[p] = 0; m_left[p] = 0; m_run[p] = 0;
      m_level[p] = 0; m_rise[p] = 0; m_fall[p] = 0; m_cfg[p] = '0;
    end
    m_err = 0;
    m_hist.delete();
    repeat (SS) m_hist.push_back('0);
  endtask

  task automatic model_step(input logic valid, input int idx, input logic [4:0] data,
                            input logic [N-1:0] di, input int thresh);
    logic [N-1:0] s;
    logic acc, wr;
    acc = valid && m_ready(idx);
    s = m_hist[0];
    void'(m_hist.pop_front());
    m_hist.push_back(di);
    m_err = acc && (idx >= N);
    for (int p = 0; p < N; p++) begin
      m_rise[p] = 0; m_fall[p] = 0;
      wr = acc && (idx == p);
      if (m_mode[p] == 0) begin
        m_level[p] = 0; m_run[p] = 0;
        if (wr && data[0]) begin m_mode[p] = 1; m_left[p] = SC; end
      end else if (m_mode[p] == 1) begin
        m_run[p] = 0;
        m_left[p]--;
        if (m_left[p] == 0) begin m_mode[p] = 2; m_level[p] = s[p]; end
      end else if (wr && !data[0]) begin
        m_mode[p] = 0; m_level[p] = 0; m_run[p] = 0;
      end else if (wr && (data[2:1] != m_cfg[p][2:1])) begin
        m_mode[p] = 1; m_left[p] = SC; m_run[p] = 0;
      end else if (s[p] == m_level[p]) begin
        m_run[p] = 0;
      end else begin
        m_run[p]++;
        if (m_run[p] > thresh) begin
          m_level[p] = s[p];
          m_rise[p] = s[p];
          m_fall[p] = !s[p];
          m_run[p] = 0;
        end
      end
      if (wr) m_cfg[p] = data;
    end
  endtask

  int rise3_n = 0;
  int fall3_n = 0;

  // One clock cycle: check combinational ready, advance model at the edge, compare everything.
  task automatic tick();
    logic [N-1:0]   e_ie, e_pu, e_pd, e_lv, e_ri, e_fa;
    logic [2*N-1:0] e_ste;
    #1;
    check("ready", cfg_ready, m_ready(int'(cfg_idx)));
    @(posedge clk_i);
    model_step(cfg_valid, int'(cfg_idx), cfg_data, pad_di, int'(deb_thresh));
    #1;
    for (int p = 0; p < N; p++) begin
      e_ie[p] = m_cfg[p][0]; e_pu[p] = m_cfg[p][1]; e_pd[p] = m_cfg[p][2];
      e_ste[2*p+:2] = m_cfg[p][4:3];
      e_lv[p] = m_level[p]; e_ri[p] = m_rise[p]; e_fa[p] = m_fall[p];
    end
    check("pad_ie", pad_ie, e_ie);
    check("pad_pu", pad_pu, e_pu);
    check("pad_pd", pad_pd, e_pd);
    check("pad_ste", pad_ste, e_ste);
    check("level", level, e_lv);
    check("rise", rise, e_ri);
    check("fall", fall, e_fa);
    check("cfg_err", cfg_err, m_err);
    rise3_n += rise[3];
    fall3_n += fall[3];
  endtask

  task automatic hold(input logic di3, input int n);
    cfg_valid = 0;
    pad_di[3] = di3;
    repeat (n) tick();
  endtask

  typedef struct {
    logic       valid;
    logic [4:0] data;
    logic       di3;
    logic       rdy;
    logic       ie3;
    logic       lvl3;
    logic       rise3;
    logic       fall3;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic [3*N+2*N-1:0] prev;

    // Enable pad 3 with input high, then a threshold-3 fall and rise.
    tbl[0] = '{1, 5'b00001, 1, 1, 1, 0, 0, 0};
    for (int i = 1; i <= 3; i++) tbl[i] = '{0, 5'b0, 1, 0, 1, 0, 0, 0};
    tbl[4] = '{0, 5'b0, 1, 0, 1, 1, 0, 0};
    for (int i = 5; i <= 9; i++) tbl[i] = '{0, 5'b0, 0, 1, 1, 1, 0, 0};
    tbl[10] = '{0, 5'b0, 0, 1, 1, 0, 0, 1};
    for (int i = 11; i <= 15; i++) tbl[i] = '{0, 5'b0, 1, 1, 1, 0, 0, 0};
    tbl[16] = '{0, 5'b0, 1, 1, 1, 1, 1, 0};
    tbl[17] = '{0, 5'b0, 1, 1, 1, 1, 0, 0};

    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_level", level, '0);
    check("rst_ie", pad_ie, '0);
    check("rst_err", cfg_err, 0);
    check("rst_ready", cfg_ready, 1);
    @(negedge clk_i);
    rst_ni = 1;

    cfg_idx = 3;
    for (int i = 0; i < 18; i++) begin
      cfg_valid = tbl[i].valid;
      cfg_data  = tbl[i].data;
      pad_di[3] = tbl[i].di3;
      #1;
      check($sformatf("tbl%0d_ready", i), cfg_ready, tbl[i].rdy);
      tick();
      check($sformatf("tbl%0d_ie3", i), pad_ie[3], tbl[i].ie3);
      check($sformatf("tbl%0d_lvl3", i), level[3], tbl[i].lvl3);
      check($sformatf("tbl%0d_rise3", i), rise[3], tbl[i].rise3);
      check($sformatf("tbl%0d_fall3", i), fall[3], tbl[i].fall3);
    end

    // Glitches: 3 synchronized cycles are filtered, 4 pass through and back.
    hold(0, 10);
    check("glitch_pre_lvl", level[3], 0);
    rise3_n = 0; fall3_n = 0;
    hold(1, 3);
    hold(0, 10);
    check("glitch3_rises", rise3_n, 0);
    check("glitch3_lvl", level[3], 0);
    hold(1, 4);
    hold(0, 12);
    check("glitch4_rises", rise3_n, 1);
    check("glitch4_falls", fall3_n, 1);
    check("glitch4_lvl", level[3], 0);

    // Out-of-range write: error pulse, no pad changes.
    prev = {pad_ie, pad_pu, pad_pd, pad_ste};
    cfg_valid = 1; cfg_idx = 7; cfg_data = 5'b11111;
    #1;
    check("oor_ready", cfg_ready, 1);
    tick();
    check("oor_err", cfg_err, 1);
    check("oor_pads", {pad_ie, pad_pu, pad_pd, pad_ste}, prev);
    cfg_valid = 0;
    tick();
    check("oor_err_once", cfg_err, 0);

    // Keeper config re-enters settling with the level held, then disable.
    cfg_idx = 3;
    hold(1, 10);
    check("keep_pre_lvl", level[3], 1);
    cfg_valid = 1; cfg_data = 5'b00111;
    tick();
    check("keep_pu", pad_pu[3], 1);
    check("keep_pd", pad_pd[3], 1);
    rise3_n = 0; fall3_n = 0;
    cfg_valid = 0;
    #1;
    check("keep_settle_ready", cfg_ready, 0);
    hold(1, 6);
    check("keep_pulses", rise3_n + fall3_n, 0);
    check("keep_lvl", level[3], 1);
    cfg_valid = 1; cfg_data = 5'b00110;
    tick();
    cfg_valid = 0;
    check("off_lvl", level[3], 0);
    check("off_fall", fall3_n, 0);
    check("off_ie", pad_ie[3], 0);

    // Reset during settling.
    cfg_valid = 1; cfg_data = 5'b00001;
    tick();
    cfg_valid = 0;
    repeat (2) tick();
    #2;
    rst_ni = 0;
    model_reset();
    #1;
    check("mid_rst_ie", pad_ie, '0);
    check("mid_rst_level", level, '0);
    check("mid_rst_pulses", {rise, fall}, '0);
    check("mid_rst_ready", cfg_ready, 1);
    @(negedge clk_i);
    rst_ni = 1;
    pad_di = '0;
    tick();
    check("post_rst_off", pad_ie[3], 0);

    // Randomized traffic across all pads against the model.
    for (int c = 0; c < 1500; c++) begin
      if (c % 97 == 0) deb_thresh = DW'($urandom_range(0, 4));
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_idx   = IW'($urandom_range(0, 7));
      cfg_data  = 5'($urandom);
      cfg_data[0] = ($urandom_range(0, 4) != 0);
      for (int p = 0; p < N; p++) begin
        if ($urandom_range(0, 5) == 0) pad_di[p] = ~pad_di[p];
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
